fetch_insn_queue: RTL and testbench



---
 rtl/fetch_insn_queue_pkg.sv | 18 +
 rtl/fetchq_ram.sv | 28 ++
 rtl/fetch_insn_queue.sv | 111 +++++++++++
 tb/tb_fetch_insn_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_insn_queue_pkg.sv
// Shared types for the fetch instruction queue: machine widths and the fetched-entry payload.
// Consumed by fetch_insn_queue, fetchq_ram and the fetch/decode wrappers.
package fetch_insn_queue_pkg;

  localparam int unsigned M_WIDTH   = 32;
  localparam int unsigned LG_PHT_SZ = 10;

  typedef struct packed {
    logic [31:0]          insn;
    logic [M_WIDTH-1:0]   pc;
    logic                 pred;
    logic [LG_PHT_SZ-1:0] pht_idx;
    logic [M_WIDTH-1:0]   pred_target;
  } fetch_entry_t;

  localparam int unsigned FetchEntryW = $bits(fetch_entry_t);

endpackage

// File: rtl/fetchq_ram.sv
// Payload storage for the fetch queue: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the queue pointers.
module fetchq_ram
  import fetch_insn_queue_pkg::*;
#(
  parameter int unsigned LgDepth = 3
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [LgDepth-1:0] waddr_i,
  input  fetch_entry_t       wdata_i,
  input  logic [LgDepth-1:0] raddr_i,
  output fetch_entry_t       rdata_o
);

  localparam int unsigned Depth = 2 ** LgDepth;

  fetch_entry_t mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_insn_queue.sv
// Instruction buffer between fetch and decode: circular queue with wrap-bit pointers and flush.
// Optional same-cycle empty-queue bypass when FETCHQ_BYPASS_EN is defined.
module fetch_insn_queue
  import fetch_insn_queue_pkg::*;
#(
  parameter int unsigned LG_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [31:0]          push_insn,
  input  logic [M_WIDTH-1:0]   push_pc,
  input  logic                 push_pred,
  input  logic [LG_PHT_SZ-1:0] push_pht_idx,
  input  logic [M_WIDTH-1:0]   push_pred_target,
  output logic                 pop_valid,
  input  logic                 pop_ready,
  output logic [31:0]          pop_insn,
  output logic [M_WIDTH-1:0]   pop_pc,
  output logic                 pop_pred,
  output logic [LG_PHT_SZ-1:0] pop_pht_idx,
  output logic [M_WIDTH-1:0]   pop_pred_target,
  output logic [LG_DEPTH:0]    occupancy,
  output logic                 empty,
  output logic                 full
);

  localparam int unsigned PtrW = LG_DEPTH + 1;

  logic [LG_DEPTH:0] head_q, head_d;
  logic [LG_DEPTH:0] tail_q, tail_d;
  logic              push_fire;
  logic              pop_fire;
  fetch_entry_t      push_entry;
  fetch_entry_t      ram_rdata;
  fetch_entry_t      pop_entry;

  assign push_entry = '{
    insn:        push_insn,
    pc:          push_pc,
    pred:        push_pred,
    pht_idx:     push_pht_idx,
    pred_target: push_pred_target
  };

  assign empty     = (head_q == tail_q);
  assign full      = (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]) &&
                     (head_q[LG_DEPTH] != tail_q[LG_DEPTH]);
  assign occupancy = tail_q - head_q;

  // Held low through reset so fetch never hands over an entry that reset will discard.
  assign push_ready = reset & ~full;

`ifdef FETCHQ_BYPASS_EN
  logic bypass_avail;

  // An entry offered to an empty queue is shown to decode in the same cycle;
  // it only lands in storage if decode does not take it.
  assign bypass_avail = empty & push_valid & push_ready;
  assign pop_valid    = reset & ~flush & (~empty | bypass_avail);
  assign pop_entry    = empty ? push_entry : ram_rdata;
  assign push_fire    = push_valid & push_ready & ~flush & ~(bypass_avail & pop_ready);
  assign pop_fire     = pop_valid & pop_ready & ~empty;
`else
  assign pop_valid = reset & ~flush & ~empty;
  assign pop_entry = ram_rdata;
  assign push_fire = push_valid & push_ready & ~flush;
  assign pop_fire  = pop_valid & pop_ready;
`endif

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_fire) begin
      head_d = head_q + PtrW'(1);
    end
    if (push_fire) begin
      tail_d = tail_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  fetchq_ram #(
    .LgDepth (LG_DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (push_fire),
    .waddr_i (tail_q[LG_DEPTH-1:0]),
    .wdata_i (push_entry),
    .raddr_i (head_q[LG_DEPTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign pop_insn        = pop_entry.insn;
  assign pop_pc          = pop_entry.pc;
  assign pop_pred        = pop_entry.pred;
  assign pop_pht_idx     = pop_entry.pht_idx;
  assign pop_pred_target = pop_entry.pred_target;

endmodule

// File: tb/tb_fetch_insn_queue.sv
// Self-checking bench for fetch_insn_queue: directed scenarios plus random traffic,
// compared against a queue-based reference model (honours FETCHQ_BYPASS_EN).
module tb_fetch_insn_queue;
  import fetch_insn_queue_pkg::*;

  localparam int unsigned LgDepth = 3;
  localparam int unsigned Depth   = 2 ** LgDepth;
`ifdef FETCHQ_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 flush;
  logic                 push_valid;
  logic                 push_ready;
  logic [31:0]          push_insn;
  logic [M_WIDTH-1:0]   push_pc;
  logic                 push_pred;
  logic [LG_PHT_SZ-1:0] push_pht_idx;
  logic [M_WIDTH-1:0]   push_pred_target;
  logic                 pop_valid;
  logic                 pop_ready;
  logic [31:0]          pop_insn;
  logic [M_WIDTH-1:0]   pop_pc;
  logic                 pop_pred;
  logic [LG_PHT_SZ-1:0] pop_pht_idx;
  logic [M_WIDTH-1:0]   pop_pred_target;
  logic [LgDepth:0]     occupancy;
  logic                 empty;
  logic                 full;

  always #5 clk = ~clk;

  fetch_insn_queue #(
    .LG_DEPTH (LgDepth)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_insn        (push_insn),
    .push_pc          (push_pc),
    .push_pred        (push_pred),
    .push_pht_idx     (push_pht_idx),
    .push_pred_target (push_pred_target),
    .pop_valid        (pop_valid),
    .pop_ready        (pop_ready),
    .pop_insn         (pop_insn),
    .pop_pc           (pop_pc),
    .pop_pred         (pop_pred),
    .pop_pht_idx      (pop_pht_idx),
    .pop_pred_target  (pop_pred_target),
    .occupancy        (occupancy),
    .empty            (empty),
    .full             (full)
  );

  int unsigned  n_assert = 0;
  int unsigned  n_fail   = 0;
  fetch_entry_t model_q[$];
  fetch_entry_t cur;
  bit           acc;
  bit           held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc, input logic [31:0] insn);
    fetch_entry_t e;
    e.insn        = insn;
    e.pc          = M_WIDTH'(pc);
    e.pred        = pc[2];
    e.pht_idx     = LG_PHT_SZ'(pc >> 2);
    e.pred_target = M_WIDTH'(pc + 32'h40);
    return e;
  endfunction

  function automatic fetch_entry_t rnd_entry();
    fetch_entry_t e;
    e.insn        = $urandom;
    e.pc          = M_WIDTH'($urandom);
    e.pred        = 1'($urandom);
    e.pht_idx     = LG_PHT_SZ'($urandom);
    e.pred_target = M_WIDTH'($urandom);
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, check just after, then update the model at the
  // rising edge. held=1 means the offered entry was refused for lack of space and must be kept.
  task automatic step(input bit rst, input bit fl, input bit pv, input bit pr,
                      output bit accepted, output bit hold);
    bit           exp_ready, exp_pv, byp_avail;
    fetch_entry_t exp_head, obs_head;
    int           sz;
    @(negedge clk);
    reset            = rst;
    flush            = fl;
    push_valid       = pv;
    pop_ready        = pr;
    push_insn        = cur.insn;
    push_pc          = cur.pc;
    push_pred        = cur.pred;
    push_pht_idx     = cur.pht_idx;
    push_pred_target = cur.pred_target;
    #1;
    sz        = model_q.size();
    exp_ready = rst && (sz < Depth);
    byp_avail = Byp && (sz == 0) && pv && exp_ready;
    exp_pv    = rst && !fl && ((sz > 0) || byp_avail);
    chk("push_ready", 128'(push_ready), 128'(exp_ready));
    chk("pop_valid", 128'(pop_valid), 128'(exp_pv));
    chk("occupancy", 128'(occupancy), 128'(sz));
    chk("empty", 128'(empty), 128'(sz == 0));
    chk("full", 128'(full), 128'(sz == Depth));
    if (exp_pv) begin
      exp_head = (sz > 0) ? model_q[0] : cur;
      obs_head = '{insn: pop_insn, pc: pop_pc, pred: pop_pred, pht_idx: pop_pht_idx,
                   pred_target: pop_pred_target};
      chk("pop_entry", 128'(obs_head), 128'(exp_head));
    end
    @(posedge clk);
    accepted = 1'b0;
    hold     = rst && !fl && pv && !exp_ready;
    if (!rst || fl) begin
      model_q.delete();
    end else begin
      if (exp_pv && pr && sz > 0) void'(model_q.pop_front());
      if (pv && exp_ready) begin
        accepted = 1'b1;
        if (!(byp_avail && pr)) model_q.push_back(cur);
      end
    end
  endtask

  initial begin
    int pushed;
    reset = 1'b0; flush = 1'b0; push_valid = 1'b0; pop_ready = 1'b0;
    cur = mk(32'h0, 32'h0);
    @(posedge clk);
    step(0, 0, 0, 0, acc, held);
    step(0, 0, 1, 1, acc, held);

    // Release and idle, then a single push that should surface one cycle later
    step(1, 0, 0, 0, acc, held);
    cur = mk(32'h1000, 32'h0000_0013);
    step(1, 0, 1, 0, acc, held);
    step(1, 0, 0, 1, acc, held);
    step(1, 0, 0, 0, acc, held);

    // Fill to capacity, offer a ninth entry, then drain in order
    for (int i = 0; i < Depth; i++) begin
      cur = mk(32'(i * 4), 32'h0000_0013 + 32'(i << 7));
      step(1, 0, 1, 0, acc, held);
    end
    cur = mk(32'h20, 32'h0000_1113);
    step(1, 0, 1, 0, acc, held);
    step(1, 0, 1, 1, acc, held);
    for (int i = 0; i < Depth + 2; i++) step(1, 0, 0, 1, acc, held);

    // Wrap-around: 20 pushes with pop_ready toggling every cycle
    pushed = 0;
    cur    = rnd_entry();
    for (int i = 0; i < 60; i++) begin
      if (pushed >= 20 && model_q.size() == 0) break;
      step(1, 0, pushed < 20, i[0], acc, held);
      if (acc) pushed++;
      if (!held) cur = rnd_entry();
    end

    // Simultaneous push/pop at occupancy 1, 7 and 8
    step(1, 0, 1, 0, acc, held); cur = rnd_entry();
    step(1, 0, 1, 1, acc, held); cur = rnd_entry();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 0, acc, held); cur = rnd_entry();
    end
    step(1, 0, 1, 1, acc, held); cur = rnd_entry();
    step(1, 0, 1, 0, acc, held); cur = rnd_entry();
    step(1, 0, 1, 1, acc, held);
    for (int i = 0; i < Depth + 1; i++) step(1, 0, 0, 1, acc, held);

    // Flush with five entries while pc 0x2000 is being pushed
    for (int i = 0; i < 5; i++) begin
      cur = rnd_entry();
      step(1, 0, 1, 0, acc, held);
    end
    cur = mk(32'h2000, 32'h0000_0093);
    step(1, 1, 1, 1, acc, held);
    step(1, 0, 0, 1, acc, held);
    step(1, 0, 0, 1, acc, held);

    // Reset mid-stream with four entries and a push pending
    for (int i = 0; i < 4; i++) begin
      cur = rnd_entry();
      step(1, 0, 1, 0, acc, held);
    end
    cur = mk(32'h3000, 32'h0000_0113);
    step(0, 0, 1, 1, acc, held);
    step(0, 0, 1, 1, acc, held);
    step(1, 0, 1, 1, acc, held);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, acc, held);

    // Random traffic with occasional flush and reset
    cur = rnd_entry();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), acc, held);
      if (!held) cur = rnd_entry();
    end
    for (int i = 0; i < Depth + 1; i++) step(1, 0, 0, 1, acc, held);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
